snake_grid_renderer: RTL and testbench
======================================

Name: snake_grid_renderer

Overview:
Pixel-pipeline stage directly downstream of the 640x480 VGA timing generator. Consumes the raw h/v counters and syncs, maps each active pixel to a 40x30 grid of 16x16-pixel cells, and looks up the cell type in an internal 1200x2 cell RAM that game logic writes. Emits 8-bit RGB (RRRGGGBB) with syncs delayed to match, plus a once-per-frame tick for game updates. Also provides a sequential RAM-clear engine.

Parameters:
HBP, 144, first active h_counter value
HFP, 784, first h_counter value past active video
VBP, 35, first active v_counter value
VFP, 515, first v_counter value past active video
COLS, 40, grid columns
ROWS, 30, grid rows
CELLS, 1200, COLS*ROWS, cell RAM depth

Ports:
pixel_clk  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous, active-low reset
h_counter  in  10  horizontal counter from timing generator
v_counter  in  10  vertical counter from timing generator
hsync_in  in  1  hsync from timing generator
vsync_in  in  1  vsync from timing generator
wr_en  in  1  cell write strobe
wr_addr  in  11  cell index, row*40+col
wr_data  in  2  cell type: 0 empty, 1 body, 2 head, 3 food
clear_req  in  1  pulse: start RAM clear
clear_busy  out  1  high while clear engine runs
rgb  out  8  pixel colour, RRRGGGBB
hsync_out  out  1  hsync delayed 2 cycles
vsync_out  out  1  vsync delayed 2 cycles
frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- Reset (rst=0, async): rgb=0, hsync_out=1, vsync_out=1, frame_tick=0, all pipeline regs cleared, active flags 0. Clear FSM is forced to CLEAR with clr_addr=0, so clear_busy=1.
- Active: HBP<=h<HFP and VBP<=v<VFP. x=h-HBP, y=v-VBP. col=x[9:4] (0..39), row=y[8:4] (0..29). addr=row*40+col computed as (row<<5)+(row<<3)+col, 11 bits.
- Stage 1 (registered): RAM read address, active_d1, x[3:0], y[3:0], hsync_d1, vsync_d1.
- Stage 2 (registered): synchronous RAM data is valid. rgb, hsync_out and vsync_out are updated.
- Latency: 2 cycles from counters/syncs to rgb/hsync_out/vsync_out.
- Colour rules: inactive -> 0x00. Type 0 -> 0x00. Type 1 -> 0x1C. Type 2 -> 0xFC. Type 3 -> 0xE0.
- Non-empty cells draw 0x00 on pixel offsets x[3:0]==15 or y[3:0]==15, giving a 1-pixel gap between segments.
- RAM: 1200x2, one write port, one read port, read-first. A write and a render read to the same address in the same cycle return the old data; the new data is visible from the next read.
- Writes with wr_addr>=1200 are ignored.
- Clear FSM states:
  - IDLE: on clear_req -> CLEAR with clr_addr=0.
  - CLEAR: writes 0 to clr_addr each cycle and increments it. After writing 1199 -> IDLE.
  - clear_busy=1 exactly while in CLEAR; a clear takes 1200 cycles.
- While clear_busy=1, wr_en is ignored. A clear_req during CLEAR is ignored (no restart).
- clear_req and wr_en in the same IDLE cycle: clear wins and the write is dropped.
- Rendering continues during a clear and shows partially cleared contents.
- frame_tick: registered. Asserted for exactly one cycle, the cycle after the input is sampled with v_counter==VFP and h_counter==0. Result: one pulse per 800*521 cycles.
- Counters entering mid-line after reset: no special handling; output becomes correct 2 cycles after reset release.

Test Plan:
- Reset release, no clear_req -> clear_busy stays 1 for exactly 1200 cycles then drops. RAM reads all 0; rgb=0x00 for a full frame.
- After clear, write addr 41 (row1,col1) type 1. Drive h=160, v=51 -> rgb=0x1C two cycles later. h=175, v=51 -> 0x00 (gap). h=159, v=51 -> 0x00 (cell 40).
- Write addr 1199 type 3. Drive h=783, v=514 -> 0x00 (gap pixel). h=782, v=513 -> 0xE0. h=784 -> 0x00 (inactive).
- Sync path: toggle hsync_in at an arbitrary cycle -> hsync_out follows exactly 2 cycles later. During reset, hsync_out=1 and vsync_out=1.
- Run free counters over 2 frames -> frame_tick pulses twice, 416800 cycles apart, each 1 cycle wide, and only after the input is sampled at v=515, h=0.
- Corner cases:
  - clear_req together with wr_en (addr 5, type 2) -> addr 5 reads 0 after the clear.
  - wr_en during busy is dropped.
  - wr_addr=1500 -> no RAM change.
  - Same-cycle write/read of addr 41 -> old colour shown, new colour on the next frame.
  - rst pulsed mid-clear -> clear_busy stays 1 and the clear restarts from 0 (1200 cycles after release).

Source files
------------

// File: rtl/snake_grid_renderer_if.sv
// Cell-RAM write/clear bus between game logic (master) and the renderer (slave).
interface snake_grid_renderer_if;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        clear_req;
  logic        clear_busy;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output clear_req,
    input  clear_busy
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  clear_req,
    output clear_busy
  );
endinterface

// File: rtl/snake_grid_renderer.sv
// Snake grid renderer: maps 640x480 active video onto a 40x30 grid of 16x16
// cells, colours each pixel from a 2-bit cell RAM, delays syncs to match and
// provides a sequential RAM-clear engine plus a once-per-frame tick.
module snake_grid_renderer (
  input  logic                        pixel_clk,
  input  logic                        rst,
  input  logic [9:0]                  h_counter,
  input  logic [9:0]                  v_counter,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  snake_grid_renderer_if.slave        cell_if,
  output logic [7:0]                  rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        frame_tick
);

  localparam int unsigned HBP   = 144;
  localparam int unsigned HFP   = 784;
  localparam int unsigned VBP   = 35;
  localparam int unsigned VFP   = 515;
  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = 11;
  localparam int unsigned CW    = 10;

  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_BODY  = 8'h1C;
  localparam logic [7:0] RGB_HEAD  = 8'hFC;
  localparam logic [7:0] RGB_FOOD  = 8'hE0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            busy_q;

  logic            active_c;
  logic [CW-1:0]   x_c;
  logic [8:0]      y_c;
  logic [5:0]      col_c;
  logic [4:0]      row_c;
  logic [AW-1:0]   rd_addr_c;

  logic            we_c;
  logic [AW-1:0]   wa_c;
  logic [1:0]      wd_c;

  logic [1:0]      cell_mem [CELLS];
  logic [1:0]      ram_q;

  logic            active_d1;
  logic [3:0]      xoff_d1;
  logic [3:0]      yoff_d1;
  logic            hsync_d1;
  logic            vsync_d1;
  logic [7:0]      pix_c;

  assign cell_if.clear_busy = busy_q;

  // Active-area decode and cell index (row*40 = row*32 + row*8); parked at 0 when blanking.
  always_comb begin
    active_c  = (h_counter >= CW'(HBP)) && (h_counter < CW'(HFP)) &&
                (v_counter >= CW'(VBP)) && (v_counter < CW'(VFP));
    x_c       = h_counter - CW'(HBP);
    y_c       = 9'(v_counter - CW'(VBP));
    col_c     = x_c[9:4];
    row_c     = y_c[8:4];
    rd_addr_c = '0;
    if (active_c) begin
      rd_addr_c = AW'({row_c, 5'b00000}) + AW'({row_c, 3'b000}) + AW'(col_c);
    end
  end

  // Write-port arbitration: clear engine owns the port; game writes need idle, no clear_req, in-range address.
  always_comb begin
    we_c = 1'b0;
    wa_c = '0;
    wd_c = '0;
    if (state_q == ST_CLEAR) begin
      we_c = 1'b1;
      wa_c = clr_addr_q;
    end else if (cell_if.wr_en && !cell_if.clear_req && (cell_if.wr_addr < AW'(CELLS))) begin
      we_c = 1'b1;
      wa_c = cell_if.wr_addr;
      wd_c = cell_if.wr_data;
    end
  end

  // Cell RAM write port.
  always_ff @(posedge pixel_clk) begin
    if (we_c) begin
      cell_mem[wa_c] <= wd_c;
    end
  end

  // Synchronous read-first port: captures the stage-1 address, old data on a same-cycle write.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      ram_q <= '0;
    end else begin
      ram_q <= cell_mem[rd_addr_c];
    end
  end

  // Clear FSM state register; busy mirrors the next state so it is high exactly while clearing.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= (state_d == ST_CLEAR);
    end
  end

  // Clear FSM next state: walk addresses 0..CELLS-1 once, ignore re-requests while busy.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cell_if.clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == AW'(CELLS - 1)) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end
    endcase
  end

  // Stage 1: pixel position within the cell, active flag and syncs travel alongside the RAM read.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      active_d1 <= 1'b0;
      xoff_d1   <= '0;
      yoff_d1   <= '0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
    end else begin
      active_d1 <= active_c;
      xoff_d1   <= x_c[3:0];
      yoff_d1   <= y_c[3:0];
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
    end
  end

  // Colour lookup; the last column/row of each cell stays black to separate segments.
  always_comb begin
    pix_c = RGB_BLACK;
    if (active_d1 && (xoff_d1 != 4'hF) && (yoff_d1 != 4'hF)) begin
      case (ram_q)
        2'd1:    pix_c = RGB_BODY;
        2'd2:    pix_c = RGB_HEAD;
        2'd3:    pix_c = RGB_FOOD;
        default: pix_c = RGB_BLACK;
      endcase
    end
  end

  // Stage 2 outputs and frame tick (fires the cycle after v=VFP, h=0 is seen).
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      rgb        <= RGB_BLACK;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= pix_c;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      frame_tick <= (v_counter == CW'(VFP)) && (h_counter == '0);
    end
  end

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Directed bench for snake_grid_renderer: table-driven pixel colours plus
// hand-written clear, sync, frame-tick and reset sequences.
module tb_snake_grid_renderer;

  logic       pixel_clk;
  logic       rst;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       frame_tick;

  snake_grid_renderer_if cell_if ();

  snake_grid_renderer dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cell_if    (cell_if),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  initial pixel_clk = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic render(input logic [9:0] h, input logic [9:0] v);
    @(negedge pixel_clk);
    h_counter = h;
    v_counter = v;
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic write_cell(input logic [10:0] a, input logic [1:0] d);
    @(negedge pixel_clk);
    cell_if.wr_en   = 1'b1;
    cell_if.wr_addr = a;
    cell_if.wr_data = d;
    @(negedge pixel_clk);
    cell_if.wr_en   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (cell_if.clear_busy && n < 2000) begin
      @(posedge pixel_clk);
      #1;
      n++;
    end
  endtask

  task automatic tick_step(input logic [9:0] h, input logic [9:0] v);
    @(negedge pixel_clk);
    h_counter = h;
    v_counter = v;
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    int n;
    int ticks;
    int tick_idx;
    int idx;

    rst               = 1'b0;
    h_counter         = 10'd160;
    v_counter         = 10'd51;
    hsync_in          = 1'b0;
    vsync_in          = 1'b0;
    cell_if.wr_en     = 1'b0;
    cell_if.wr_addr   = '0;
    cell_if.wr_data   = '0;
    cell_if.clear_req = 1'b0;

    // Reset state
    repeat (3) @(posedge pixel_clk);
    #1;
    check("reset_rgb", 32'(rgb), 32'h00);
    check("reset_hsync", 32'(hsync_out), 32'h1);
    check("reset_vsync", 32'(vsync_out), 32'h1);
    check("reset_tick", 32'(frame_tick), 32'h0);
    check("reset_busy", 32'(cell_if.clear_busy), 32'h1);
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    @(negedge pixel_clk);
    rst = 1'b1;
    count_busy(n);
    check("reset_clear_len", 32'(n), 32'd1200);

    // Empty RAM renders black
    render(10'd160, 10'd51);
    check("empty_160_51", 32'(rgb), 32'h00);
    render(10'd782, 10'd513);
    check("empty_782_513", 32'(rgb), 32'h00);

    write_cell(11'd41, 2'd1);
    write_cell(11'd1199, 2'd3);
    write_cell(11'd0, 2'd2);
    write_cell(11'd702, 2'd2);
    write_cell(11'd1500, 2'd3);

    vecs[0]  = '{10'd160, 10'd51,  8'h1C};
    vecs[1]  = '{10'd175, 10'd51,  8'h00};
    vecs[2]  = '{10'd159, 10'd51,  8'h00};
    vecs[3]  = '{10'd160, 10'd66,  8'h00};
    vecs[4]  = '{10'd174, 10'd65,  8'h1C};
    vecs[5]  = '{10'd783, 10'd514, 8'h00};
    vecs[6]  = '{10'd782, 10'd513, 8'hE0};
    vecs[7]  = '{10'd784, 10'd513, 8'h00};
    vecs[8]  = '{10'd782, 10'd515, 8'h00};
    vecs[9]  = '{10'd144, 10'd35,  8'hFC};
    vecs[10] = '{10'd143, 10'd35,  8'h00};
    vecs[11] = '{10'd144, 10'd34,  8'h00};
    vecs[12] = '{10'd159, 10'd35,  8'h00};
    vecs[13] = '{10'd501, 10'd314, 8'hFC};
    vecs[14] = '{10'd485, 10'd314, 8'h00};
    vecs[15] = '{10'd501, 10'd330, 8'h00};

    for (int i = 0; i < 16; i++) begin
      render(vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d_h%0d_v%0d", i, vecs[i].h, vecs[i].v), 32'(rgb), 32'(vecs[i].exp));
    end

    // Sync path: 2-cycle delay
    @(negedge pixel_clk);
    hsync_in = 1'b0;
    @(posedge pixel_clk);
    #1;
    check("hsync_after_1", 32'(hsync_out), 32'h1);
    @(posedge pixel_clk);
    #1;
    check("hsync_after_2", 32'(hsync_out), 32'h0);
    @(negedge pixel_clk);
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    @(posedge pixel_clk);
    #1;
    check("vsync_after_1", 32'(vsync_out), 32'h1);
    check("hsync_rise_after_1", 32'(hsync_out), 32'h0);
    @(posedge pixel_clk);
    #1;
    check("vsync_after_2", 32'(vsync_out), 32'h0);
    check("hsync_rise_after_2", 32'(hsync_out), 32'h1);
    @(negedge pixel_clk);
    vsync_in = 1'b1;

    // Frame tick directed points
    tick_step(10'd0, 10'd514);
    check("tick_v514_h0", 32'(frame_tick), 32'h0);
    tick_step(10'd1, 10'd515);
    check("tick_v515_h1", 32'(frame_tick), 32'h0);
    tick_step(10'd0, 10'd515);
    check("tick_v515_h0", 32'(frame_tick), 32'h1);
    tick_step(10'd1, 10'd515);
    check("tick_width", 32'(frame_tick), 32'h0);

    // Frame tick over two scanlines of counting
    ticks    = 0;
    tick_idx = -1;
    idx      = 0;
    for (int vv = 514; vv <= 515; vv++) begin
      for (int hh = 0; hh < 800; hh++) begin
        tick_step(10'(hh), 10'(vv));
        if (frame_tick) begin
          ticks++;
          if (tick_idx < 0) tick_idx = idx;
        end
        idx++;
      end
    end
    check("tick_count_sweep", 32'(ticks), 32'd1);
    check("tick_pos_sweep", 32'(tick_idx), 32'd800);

    // Clear request collides with a write; busy writes dropped; re-request ignored
    @(negedge pixel_clk);
    h_counter         = 10'd224;
    v_counter         = 10'd35;
    cell_if.clear_req = 1'b1;
    cell_if.wr_en     = 1'b1;
    cell_if.wr_addr   = 11'd5;
    cell_if.wr_data   = 2'd2;
    @(posedge pixel_clk);
    #1;
    check("clear_busy_start", 32'(cell_if.clear_busy), 32'h1);
    n = 1;
    for (int k = 1; k < 2000; k++) begin
      @(negedge pixel_clk);
      cell_if.clear_req = 1'b0;
      cell_if.wr_en     = 1'b0;
      if (k == 10) begin
        cell_if.wr_en   = 1'b1;
        cell_if.wr_addr = 11'd0;
        cell_if.wr_data = 2'd2;
      end
      if (k == 20) cell_if.clear_req = 1'b1;
      if (k == 30) begin
        h_counter = 10'd782;
        v_counter = 10'd513;
      end
      @(posedge pixel_clk);
      #1;
      if (k == 2) check("clear_wins_over_write", 32'(rgb), 32'h00);
      if (k == 31) check("partial_clear_visible", 32'(rgb), 32'hE0);
      if (!cell_if.clear_busy) break;
      n++;
    end
    check("clear_len_with_rerequest", 32'(n), 32'd1200);
    render(10'd144, 10'd35);
    check("busy_write_dropped", 32'(rgb), 32'h00);
    render(10'd224, 10'd35);
    check("cell5_after_clear", 32'(rgb), 32'h00);
    render(10'd782, 10'd513);
    check("cell1199_cleared", 32'(rgb), 32'h00);
    render(10'd501, 10'd314);
    check("cell702_cleared", 32'(rgb), 32'h00);

    // Same-cycle write/read of cell 41: old colour first, new colour next read
    write_cell(11'd41, 2'd1);
    render(10'd160, 10'd51);
    check("cell41_body", 32'(rgb), 32'h1C);
    @(negedge pixel_clk);
    cell_if.wr_en   = 1'b1;
    cell_if.wr_addr = 11'd41;
    cell_if.wr_data = 2'd2;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    cell_if.wr_en = 1'b0;
    @(posedge pixel_clk);
    #1;
    check("same_cycle_old_data", 32'(rgb), 32'h1C);
    @(posedge pixel_clk);
    #1;
    check("same_cycle_new_data", 32'(rgb), 32'hFC);

    // Reset in the middle of a clear restarts it from address 0
    write_cell(11'd1199, 2'd3);
    @(negedge pixel_clk);
    h_counter         = 10'd782;
    v_counter         = 10'd513;
    cell_if.clear_req = 1'b1;
    @(negedge pixel_clk);
    cell_if.clear_req = 1'b0;
    repeat (300) @(posedge pixel_clk);
    #1;
    check("pre_reset_food", 32'(rgb), 32'hE0);
    @(negedge pixel_clk);
    rst = 1'b0;
    #5;
    check("midreset_busy", 32'(cell_if.clear_busy), 32'h1);
    check("midreset_rgb", 32'(rgb), 32'h00);
    check("midreset_hsync", 32'(hsync_out), 32'h1);
    @(negedge pixel_clk);
    rst = 1'b1;
    count_busy(n);
    check("midreset_clear_len", 32'(n), 32'd1200);
    render(10'd782, 10'd513);
    check("midreset_cell1199_cleared", 32'(rgb), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
